// File: rtl/dvi_pkg.sv
// Shared DVI/TMDS constants and types: symbol and disparity widths, control tokens,
// and the stage-1 transition-minimising chain.
package dvi_pkg;

    localparam int SYM_W  = 10;
    localparam int DISP_W = 5;

    typedef logic [SYM_W-1:0]         sym_t;
    typedef logic signed [DISP_W-1:0] disp_t;

    // Indexed by {c1,c0}; bit 0 of each token is sent first.
    localparam sym_t CTRL_TOKEN [0:3] = '{
        10'b1101010100,
        10'b0010101011,
        10'b0101010100,
        10'b1010101011
    };

    // q_m[8] records the chosen mode: 1 = XOR chain, 0 = XNOR chain.
    function automatic logic [8:0] tm_encode(input logic [7:0] d, input logic xnor_mode);
        logic [8:0] q_m;
        q_m    = '0;
        q_m[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            q_m[i] = xnor_mode ? ~(q_m[i-1] ^ d[i]) : (q_m[i-1] ^ d[i]);
        end
        q_m[8] = ~xnor_mode;
        return q_m;
    endfunction

endpackage

// File: rtl/tmds_encoder_popcount8.sv
// Combinational ones-count of an 8-bit vector.
// Latency 0; no flow control.
module popcount8 (
    input  logic [7:0] d_i,
    output logic [3:0] cnt_o
);

    always_comb begin
        cnt_o = 4'd0;
        for (int i = 0; i < 8; i++) begin
            cnt_o = cnt_o + {3'b000, d_i[i]};
        end
    end

endmodule

// File: rtl/tmds_encoder.sv
// DVI TMDS 8b/10b encoder for one colour channel: stage 1 minimises transitions, stage 2 balances DC.
// Latency 2 clocks, one symbol per clock, no backpressure.
module tmds_encoder
    import dvi_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             de_i,
    input  logic [7:0]       d_i,
    input  logic [1:0]       c_i,
    output logic [SYM_W-1:0] q_o
);

    // Stage 1
    logic [3:0] n1_d;
    logic       xnor_mode;
    logic [8:0] q_m_d, q_m_q;
    logic       de_d,  de_q;
    logic [1:0] c_d,   c_q;

    popcount8 u_pop_s1 (
        .d_i   (d_i),
        .cnt_o (n1_d)
    );

    always_comb begin
        xnor_mode = (n1_d > 4'd4) || ((n1_d == 4'd4) && !d_i[0]);
        q_m_d     = tm_encode(d_i, xnor_mode);
        de_d      = de_i;
        c_d       = c_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_m_q <= '0;
            de_q  <= 1'b0;
            c_q   <= 2'b00;
        end else begin
            q_m_q <= q_m_d;
            de_q  <= de_d;
            c_q   <= c_d;
        end
    end

    // Stage 2
    logic [3:0] n1q, n0q;
    disp_t      n1s, n0s, bal;
    disp_t      cnt_d, cnt_q;
    sym_t       q_d, q_q;

    popcount8 u_pop_s2 (
        .d_i   (q_m_q[7:0]),
        .cnt_o (n1q)
    );

    always_comb begin
        n0q   = 4'd8 - n1q;
        n1s   = $signed({1'b0, n1q});
        n0s   = $signed({1'b0, n0q});
        bal   = n1s - n0s;
        q_d   = q_q;
        cnt_d = cnt_q;
        if (!de_q) begin
            q_d   = CTRL_TOKEN[c_q];
            cnt_d = '0;
        end else if ((cnt_q == 5'sd0) || (n1q == n0q)) begin
            q_d   = {~q_m_q[8], q_m_q[8], (q_m_q[8] ? q_m_q[7:0] : ~q_m_q[7:0])};
            cnt_d = q_m_q[8] ? (cnt_q + bal) : (cnt_q - bal);
        end else if (((cnt_q > 5'sd0) && (n1q > n0q)) || ((cnt_q < 5'sd0) && (n0q > n1q))) begin
            // Invert the data to pull the running disparity back toward zero.
            q_d   = {1'b1, q_m_q[8], ~q_m_q[7:0]};
            cnt_d = cnt_q - bal + (q_m_q[8] ? 5'sd2 : 5'sd0);
        end else begin
            q_d   = {1'b0, q_m_q[8], q_m_q[7:0]};
            cnt_d = cnt_q + bal - (q_m_q[8] ? 5'sd0 : 5'sd2);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q   <= CTRL_TOKEN[0];
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o = q_q;

endmodule
